// File: rtl/washer_pkg.sv
// Shared types and default timing constants for the washer motor driver and its controller bench.
package washer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_RUN,
        S_DEAD,
        S_FAULT
    } mdrv_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int DEF_DEAD_CYC      = 20;
    localparam int DEF_RAMP_STEP_CYC = 4;
    localparam int DEF_PWM_BITS      = 4;

endpackage

// File: rtl/washer_pwm_gen.sv
// Free-running PWM counter with duty compare; force_on overrides the compare at full drive.
module washer_pwm_gen
    import washer_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                force_on,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt;

    // Wraps naturally from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pwm = force_on | (en & (cnt < duty));

endmodule

// File: rtl/washer_motor_drv.sv
// Interlocked motor bridge driver: soft-start ramp, enforced coast time, sticky illegal-command fault.
module washer_motor_drv
    import washer_pkg::*;
#(
    parameter int DEAD_CYC      = DEF_DEAD_CYC,
    parameter int RAMP_STEP_CYC = DEF_RAMP_STEP_CYC,
    parameter int PWM_BITS      = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                zheng,
    input  logic                fan,
    input  logic                alarm,
    input  logic                emergency,
    output logic                mot_fwd,
    output logic                mot_rev,
    output logic                mot_pwm,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy,
    output logic                fault
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_LAST = DUTY_MAX - 1'b1;
    localparam logic [7:0]          DEAD_LOAD = 8'(DEAD_CYC - 1);
    localparam logic [7:0]          RAMP_LAST = 8'(RAMP_STEP_CYC - 1);

    mdrv_state_t state;
    mdrv_state_t state_next;
    logic        dir;
    logic [7:0]  dead_cnt;
    logic [7:0]  ramp_cnt;

    logic cmd_fwd;
    logic cmd_rev;
    logic cmd_ill;
    logic stop_req;
    logic cmd_lost;
    logic ramp_wrap;

    assign cmd_fwd   = zheng & ~fan;
    assign cmd_rev   = fan & ~zheng;
    assign cmd_ill   = zheng & fan;
    assign stop_req  = emergency | alarm;
    assign cmd_lost  = (dir == DIR_FWD) ? ~cmd_fwd : ~cmd_rev;
    assign ramp_wrap = (ramp_cnt == RAMP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state != S_FAULT) begin
            if (cmd_ill) begin
                state_next = S_FAULT;
            end else if (stop_req) begin
                state_next = S_DEAD;
            end else begin
                case (state)
                    S_IDLE: if (cmd_fwd | cmd_rev) state_next = S_RAMP;
                    S_RAMP: begin
                        if (cmd_lost) begin
                            state_next = S_DEAD;
                        end else if (ramp_wrap && (duty >= DUTY_LAST)) begin
                            state_next = S_RUN;
                        end
                    end
                    S_RUN:  if (cmd_lost) state_next = S_DEAD;
                    S_DEAD: if (dead_cnt == 8'd0) state_next = S_IDLE;
                    default: state_next = state;
                endcase
            end
        end
    end

    // Datapath registers follow the state being entered, so a stop on a wrap edge clears duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir      <= DIR_FWD;
            duty     <= '0;
            ramp_cnt <= '0;
            dead_cnt <= '0;
        end else begin
            case (state_next)
                S_RAMP: begin
                    if (state == S_IDLE) begin
                        dir      <= cmd_rev ? DIR_REV : DIR_FWD;
                        duty     <= {{(PWM_BITS-1){1'b0}}, 1'b1};
                        ramp_cnt <= '0;
                    end else if (ramp_wrap) begin
                        duty     <= duty + 1'b1;
                        ramp_cnt <= '0;
                    end else begin
                        ramp_cnt <= ramp_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    duty     <= DUTY_MAX;
                    ramp_cnt <= '0;
                end
                S_DEAD: begin
                    duty     <= '0;
                    ramp_cnt <= '0;
                    if ((state != S_DEAD) || stop_req) begin
                        dead_cnt <= DEAD_LOAD;
                    end else if (dead_cnt != 8'd0) begin
                        dead_cnt <= dead_cnt - 8'd1;
                    end
                end
                default: begin
                    duty     <= '0;
                    ramp_cnt <= '0;
                    dead_cnt <= '0;
                end
            endcase
        end
    end

    // Leg enables decode only from registers, so both legs can never be high together.
    always_comb begin
        mot_fwd = 1'b0;
        mot_rev = 1'b0;
        busy    = (state != S_IDLE);
        fault   = (state == S_FAULT);
        if ((state == S_RAMP) || (state == S_RUN)) begin
            mot_fwd = (dir == DIR_FWD);
            mot_rev = (dir == DIR_REV);
        end
    end

    washer_pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .en      (state == S_RAMP),
        .duty    (duty),
        .force_on(state == S_RUN),
        .pwm     (mot_pwm)
    );

endmodule

// File: tb/tb_washer_motor_drv.sv
// Bench for washer_motor_drv: vector table plus directed multi-cycle sequences.
module tb_washer_motor_drv;

    typedef struct {
        logic       rst;
        logic       zheng;
        logic       fan;
        logic       alarm;
        logic       emergency;
        logic       exp_fwd;
        logic       exp_rev;
        logic       exp_busy;
        logic       exp_fault;
        logic [3:0] exp_duty;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zheng = 1'b0;
    logic       fan = 1'b0;
    logic       alarm = 1'b0;
    logic       emergency = 1'b0;
    logic       mot_fwd;
    logic       mot_rev;
    logic       mot_pwm;
    logic [3:0] duty;
    logic       busy;
    logic       fault;

    logic       rst5 = 1'b1;
    logic       zheng5 = 1'b0;
    logic       mot_fwd5;
    logic       mot_rev5;
    logic       mot_pwm5;
    logic [3:0] duty5;
    logic       busy5;
    logic       fault5;
    logic [3:0] pcnt5;

    int checks = 0;
    int errors = 0;

    vec_t tbl[24];

    always #5 clk = ~clk;

    washer_motor_drv dut (
        .clk      (clk),
        .rst      (rst),
        .zheng    (zheng),
        .fan      (fan),
        .alarm    (alarm),
        .emergency(emergency),
        .mot_fwd  (mot_fwd),
        .mot_rev  (mot_rev),
        .mot_pwm  (mot_pwm),
        .duty     (duty),
        .busy     (busy),
        .fault    (fault)
    );

    washer_motor_drv #(
        .DEAD_CYC     (20),
        .RAMP_STEP_CYC(255),
        .PWM_BITS     (4)
    ) dut5 (
        .clk      (clk),
        .rst      (rst5),
        .zheng    (zheng5),
        .fan      (1'b0),
        .alarm    (1'b0),
        .emergency(1'b0),
        .mot_fwd  (mot_fwd5),
        .mot_rev  (mot_rev5),
        .mot_pwm  (mot_pwm5),
        .duty     (duty5),
        .busy     (busy5),
        .fault    (fault5)
    );

    // Reference PWM counter for the slow-ramp instance.
    always @(posedge clk) begin
        if (rst5) pcnt5 <= 4'd0;
        else      pcnt5 <= pcnt5 + 4'd1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput("interlock", int'(mot_fwd & mot_rev), 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        zheng     = v.zheng;
        fan       = v.fan;
        alarm     = v.alarm;
        emergency = v.emergency;
    endtask

    task automatic goRun();
        rst = 1'b1; zheng = 1'b0; fan = 1'b0; alarm = 1'b0; emergency = 1'b0;
        step();
        rst = 1'b0; zheng = 1'b1;
        repeat (57) step();
        checkOutput("run_duty", int'(duty), 15);
    endtask

    initial begin
        //                rst z  f  a  e   fwd rev busy flt duty
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[3]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[6]  = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 2};
        tbl[7]  = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 0,  0, 0, 1, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0,  0, 0, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 0,  0, 1, 1, 0, 1};
        tbl[12] = '{0, 0, 1, 1, 0,  0, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 1, 0, 1,  0, 0, 1, 1, 0};
        tbl[15] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 1,  0, 0, 1, 0, 0};
        tbl[17] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[18] = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[19] = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[20] = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[21] = '{0, 1, 0, 0, 0,  1, 0, 1, 0, 1};
        tbl[22] = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[23] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i]);
            step();
            checkOutput($sformatf("v%0d_fwd", i),   int'(mot_fwd), int'(tbl[i].exp_fwd));
            checkOutput($sformatf("v%0d_rev", i),   int'(mot_rev), int'(tbl[i].exp_rev));
            checkOutput($sformatf("v%0d_busy", i),  int'(busy),    int'(tbl[i].exp_busy));
            checkOutput($sformatf("v%0d_fault", i), int'(fault),   int'(tbl[i].exp_fault));
            checkOutput($sformatf("v%0d_duty", i),  int'(duty),    int'(tbl[i].exp_duty));
        end

        // Forward soft start: duty = 1 + k/4 at k cycles after RAMP entry, RUN at k = 56.
        rst = 1'b1; zheng = 1'b0; fan = 1'b0; alarm = 1'b0; emergency = 1'b0;
        step();
        rst = 1'b0; zheng = 1'b1;
        for (int k = 0; k <= 56; k++) begin
            step();
            checkOutput($sformatf("ramp_duty_k%0d", k), int'(duty), (k / 4 + 1 > 15) ? 15 : k / 4 + 1);
            checkOutput("ramp_fwd", int'(mot_fwd), 1);
            checkOutput("ramp_rev", int'(mot_rev), 0);
        end
        for (int k = 0; k < 16; k++) begin
            step();
            checkOutput("run_pwm", int'(mot_pwm), 1);
            checkOutput("run_duty_hold", int'(duty), 15);
        end

        // Reverse while running: legs off, then rev exactly 22 cycles after the change.
        zheng = 1'b0; fan = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (i <= 21) begin
                checkOutput($sformatf("rev_dead_fwd_%0d", i), int'(mot_fwd), 0);
                checkOutput($sformatf("rev_dead_rev_%0d", i), int'(mot_rev), 0);
                checkOutput("rev_dead_pwm", int'(mot_pwm), 0);
            end else begin
                checkOutput("rev_redrive", int'(mot_rev), 1);
                checkOutput("rev_redrive_duty", int'(duty), 1);
            end
        end

        // Illegal command mid-RAMP latches FAULT until reset.
        zheng = 1'b1; fan = 1'b1;
        step();
        checkOutput("ill_fault", int'(fault), 1);
        checkOutput("ill_fwd", int'(mot_fwd), 0);
        checkOutput("ill_rev", int'(mot_rev), 0);
        checkOutput("ill_pwm", int'(mot_pwm), 0);
        zheng = 1'b0; fan = 1'b0;
        repeat (5) step();
        checkOutput("ill_sticky", int'(fault), 1);
        checkOutput("ill_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        checkOutput("ill_clear", int'(fault), 0);
        checkOutput("ill_clear_busy", int'(busy), 0);

        // Emergency held 50 cycles in RUN, then full dead time after release.
        goRun();
        emergency = 1'b1; zheng = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            checkOutput("emg_legs", int'(mot_fwd | mot_rev), 0);
            checkOutput("emg_busy", int'(busy), 1);
        end
        emergency = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checkOutput($sformatf("emg_release_busy_%0d", i), int'(busy), (i < 20) ? 1 : 0);
        end

        // Reset mid-DEAD with zheng held: IDLE immediately, new RAMP one cycle after reset drops.
        rst = 1'b1; step();
        rst = 1'b0; zheng = 1'b1; step();
        zheng = 1'b0; step();
        zheng = 1'b1;
        repeat (9) begin
            step();
            checkOutput("dead_ignore_fwd", int'(mot_fwd), 0);
            checkOutput("dead_busy", int'(busy), 1);
        end
        rst = 1'b1;
        step();
        checkOutput("rstdead_busy", int'(busy), 0);
        checkOutput("rstdead_legs", int'(mot_fwd | mot_rev | mot_pwm), 0);
        checkOutput("rstdead_duty", int'(duty), 0);
        checkOutput("rstdead_fault", int'(fault), 0);
        rst = 1'b0;
        step();
        checkOutput("rstdead_restart_fwd", int'(mot_fwd), 1);
        checkOutput("rstdead_restart_duty", int'(duty), 1);
        zheng = 1'b0;

        // Slow ramp held at duty 5: pwm high while reference counter < 5.
        begin
            int highs;
            highs = 0;
            rst5 = 1'b1; step();
            rst5 = 1'b0; zheng5 = 1'b1; step();
            checkOutput("pwm5_entry_duty", int'(duty5), 1);
            repeat (1020) step();
            checkOutput("pwm5_duty", int'(duty5), 5);
            for (int i = 0; i < 32; i++) begin
                step();
                checkOutput($sformatf("pwm5_cyc%0d", i), int'(mot_pwm5), (pcnt5 < 4'd5) ? 1 : 0);
                checkOutput("pwm5_interlock", int'(mot_fwd5 & mot_rev5), 0);
                if (mot_pwm5) highs++;
            end
            checkOutput("pwm5_high_count", highs, 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
